pulse_cmd_ctrl: RTL and testbench

Byte-level command controller between the RS232 deserializer/serializer and the pulse generator's register bank. Parses 'W' (write) and 'R' (read) frames from the RX byte stream, issues single-cycle register-bus transactions, and queues reply bytes for the serializer. To both UART blocks it presents their existing FIFO-style handshake, so no external FIFOs are needed.

---
 rtl/pulse_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pulse_cmd_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_ctrl.sv
// Command controller: parses W/R frames from the UART RX stream into register-bus cycles.
// Define PULSE_CMD_TIMEOUT_EN to abandon a partial frame after P_TIMEOUT_CYC idle cycles.
module pulse_cmd_ctrl #(
  parameter int unsigned P_CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned P_TIMEOUT_CYC = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_fifo_data,
  input  logic        rx_fifo_wr_en,
  output logic        rx_fifo_full,
  output logic [7:0]  tx_fifo_data,
  output logic        tx_fifo_empty,
  input  logic        tx_fifo_rd_en,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_BUS_WR,
    S_BUS_RD,
    S_RD_CAP,
    S_RESP
  } state_t;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  state_t      state;
  state_t      state_nxt;
  logic        is_rd;
  logic        is_rd_nxt;
  logic [7:0]  addr_nxt;
  logic [15:0] wdata_nxt;
  logic [1:0]  tx_cnt;
  logic [1:0]  tx_cnt_nxt;
  logic [7:0]  tx_b0;
  logic [7:0]  tx_b1;
  logic [7:0]  tx_b0_nxt;
  logic [7:0]  tx_b1_nxt;
  logic        err_nxt;
  logic        accept;
  logic        pop;
  logic        tmo;
  logic        unused_cfg;

  assign accept = rx_fifo_wr_en && !rx_fifo_full;
  assign pop    = tx_fifo_rd_en && (tx_cnt != 2'd0);
  assign tx_fifo_data = tx_b0;
  assign unused_cfg = ^{P_CLK_FREQ_HZ, P_TIMEOUT_CYC};

`ifdef PULSE_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        in_frame;

  assign in_frame = (state == S_ADDR) ||
                    (state == S_DHI)  ||
                    (state == S_DLO);
  assign tmo = in_frame && !accept &&
               (tmo_cnt >= P_TIMEOUT_CYC - 1);

  always_ff @(posedge clk) begin
    if (rst || !in_frame || accept || tmo) begin
      tmo_cnt <= 32'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    is_rd_nxt  = is_rd;
    addr_nxt   = reg_addr;
    wdata_nxt  = reg_wdata;
    tx_b0_nxt  = tx_b0;
    tx_b1_nxt  = tx_b1;
    tx_cnt_nxt = tx_cnt;
    err_nxt    = rx_fifo_wr_en && rx_fifo_full;

    if (pop) begin
      tx_b0_nxt  = tx_b1;
      tx_b1_nxt  = 8'h00;
      tx_cnt_nxt = tx_cnt - 2'd1;
    end

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (rx_fifo_data == OP_WR ||
              rx_fifo_data == OP_RD) begin
            is_rd_nxt = (rx_fifo_data == OP_RD);
            state_nxt = S_ADDR;
          end else begin
            tx_b0_nxt  = RSP_BAD;
            tx_cnt_nxt = 2'd1;
            err_nxt    = 1'b1;
            state_nxt  = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_nxt  = rx_fifo_data;
          state_nxt = is_rd ? S_BUS_RD : S_DHI;
        end
      end
      S_DHI: begin
        if (accept) begin
          wdata_nxt[15:8] = rx_fifo_data;
          state_nxt       = S_DLO;
        end
      end
      S_DLO: begin
        if (accept) begin
          wdata_nxt[7:0] = rx_fifo_data;
          state_nxt      = S_BUS_WR;
        end
      end
      S_BUS_WR: begin
        tx_b0_nxt  = RSP_OK;
        tx_cnt_nxt = 2'd1;
        state_nxt  = S_RESP;
      end
      S_BUS_RD: begin
        state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        tx_b0_nxt  = reg_rdata[15:8];
        tx_b1_nxt  = reg_rdata[7:0];
        tx_cnt_nxt = 2'd2;
        state_nxt  = S_RESP;
      end
      S_RESP: begin
        if (tx_cnt_nxt == 2'd0) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (tmo) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      is_rd         <= 1'b0;
      reg_addr      <= 8'h00;
      reg_wdata     <= 16'h0000;
      tx_b0         <= 8'h00;
      tx_b1         <= 8'h00;
      tx_cnt        <= 2'd0;
      tx_fifo_empty <= 1'b1;
      rx_fifo_full  <= 1'b0;
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      is_rd         <= is_rd_nxt;
      reg_addr      <= addr_nxt;
      reg_wdata     <= wdata_nxt;
      tx_b0         <= tx_b0_nxt;
      tx_b1         <= tx_b1_nxt;
      tx_cnt        <= tx_cnt_nxt;
      tx_fifo_empty <= (tx_cnt_nxt == 2'd0);
      rx_fifo_full  <= (state_nxt == S_BUS_WR) ||
                       (state_nxt == S_BUS_RD) ||
                       (state_nxt == S_RD_CAP) ||
                       (state_nxt == S_RESP);
      reg_wr        <= (state_nxt == S_BUS_WR);
      reg_rd        <= (state_nxt == S_BUS_RD);
      frame_err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_cmd_ctrl.sv
// Scoreboard bench for pulse_cmd_ctrl: frame-level reference model, random frames.
// Timeout section follows PULSE_CMD_TIMEOUT_EN.
module tb_pulse_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_fifo_data = 8'h00;
  logic        rx_fifo_wr_en = 1'b0;
  logic        rx_fifo_full;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_empty;
  logic        tx_fifo_rd_en = 1'b0;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata = 16'h0000;
  logic        frame_err;

  pulse_cmd_ctrl #(
    .P_CLK_FREQ_HZ(50_000_000),
    .P_TIMEOUT_CYC(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_fifo_data(rx_fifo_data),
    .rx_fifo_wr_en(rx_fifo_wr_en),
    .rx_fifo_full(rx_fifo_full),
    .tx_fifo_data(tx_fifo_data),
    .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_rd_en(tx_fifo_rd_en),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr(reg_wr),
    .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          err_pend = 0;
  logic [7:0]  exp_tx[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] ref_mem[256];
  logic [15:0] slave_mem[256];
  logic        ser_en = 1'b1;
  logic        rd_pend = 1'b0;
  logic        last_pop = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name,
                       input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  // Register-bank stand-in: rdata valid only the cycle after reg_rd.
  always @(negedge clk) begin
    if (reg_wr) slave_mem[reg_addr] = reg_wdata;
    reg_rdata = rd_pend ? slave_mem[reg_addr] : 16'($urandom);
    rd_pend = reg_rd;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr) begin
        if (exp_wr.size() == 0)
          unexp("reg_wr", 32'({reg_addr, reg_wdata}));
        else
          chk("reg_wr_txn", 32'({reg_addr, reg_wdata}),
              32'(exp_wr.pop_front()));
      end
      if (reg_rd) begin
        if (exp_rd.size() == 0)
          unexp("reg_rd", 32'(reg_addr));
        else
          chk("reg_rd_addr", 32'(reg_addr),
              32'(exp_rd.pop_front()));
      end
      if (frame_err) begin
        if (err_pend == 0) unexp("frame_err", 32'd1);
        else begin
          checks++;
          err_pend--;
        end
      end
    end
  end

  // Serializer: random pops, plus stray pops while empty.
  always @(negedge clk) begin
    if (last_pop) begin
      chk("empty_after_last_pop", 32'(tx_fifo_empty), 32'd1);
      chk("rx_open_after_last_pop", 32'(rx_fifo_full), 32'd0);
    end
    last_pop = 1'b0;
    tx_fifo_rd_en = 1'b0;
    if (!rst && ser_en && !tx_fifo_empty &&
        $urandom_range(0, 1) == 1) begin
      tx_fifo_rd_en = 1'b1;
      if (exp_tx.size() == 0)
        unexp("tx_byte", 32'(tx_fifo_data));
      else begin
        chk("tx_byte", 32'(tx_fifo_data),
            32'(exp_tx.pop_front()));
        last_pop = (exp_tx.size() == 0);
      end
    end else if (!rst && tx_fifo_empty &&
                 $urandom_range(0, 3) == 0) begin
      tx_fifo_rd_en = 1'b1;
    end
  end

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (rx_fifo_full && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_wait: got full=1 expected 0");
    end
    rx_fifo_data = b;
    rx_fifo_wr_en = 1'b1;
    @(negedge clk);
    rx_fifo_wr_en = 1'b0;
    rx_fifo_data = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx.size() != 0 || !tx_fifo_empty) &&
           n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n == 300) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_tx.size());
    end
  endtask

  task automatic frame_wr(input logic [7:0] a,
                          input logic [15:0] d);
    exp_wr.push_back({a, d});
    exp_tx.push_back(8'h4B);
    ref_mem[a] = d;
    send_byte(8'h57); gap();
    send_byte(a);     gap();
    send_byte(d[15:8]); gap();
    send_byte(d[7:0]);
  endtask

  task automatic frame_rd(input logic [7:0] a);
    logic [15:0] d;
    d = ref_mem[a];
    exp_rd.push_back(a);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
    send_byte(8'h52); gap();
    send_byte(a);
  endtask

  task automatic frame_bad(input logic [7:0] op);
    exp_tx.push_back(8'h3F);
    err_pend++;
    send_byte(op);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rx_full", 32'(rx_fifo_full), 32'd0);
    chk("rst_tx_empty", 32'(tx_fifo_empty), 32'd1);
    chk("rst_tx_data", 32'(tx_fifo_data), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_wr", 32'(reg_wr), 32'd0);
    chk("rst_rd", 32'(reg_rd), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int n;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'(i * 313) ^ 16'h5A3C;
      slave_mem[i] = 16'(i * 313) ^ 16'h5A3C;
    end
    ref_mem[5] = 16'hBEEF;
    slave_mem[5] = 16'hBEEF;

    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    ser_en = 1'b0;
    frame_wr(8'h03, 16'h1234);
    chk("wr_strobe_lat", 32'(reg_wr), 32'd1);
    chk("wr_addr", 32'(reg_addr), 32'h03);
    chk("wr_data", 32'(reg_wdata), 32'h1234);
    @(negedge clk);
    chk("wr_reply_lat", 32'(tx_fifo_empty), 32'd0);
    chk("wr_reply_byte", 32'(tx_fifo_data), 32'h4B);
    ser_en = 1'b1;
    drain();
    chk("addr_hold", 32'(reg_addr), 32'h03);
    chk("wdata_hold", 32'(reg_wdata), 32'h1234);

    ser_en = 1'b0;
    frame_rd(8'h05);
    chk("rd_strobe_lat", 32'(reg_rd), 32'd1);
    @(negedge clk);
    chk("rd_reply_not_yet", 32'(tx_fifo_empty), 32'd1);
    @(negedge clk);
    chk("rd_reply_lat", 32'(tx_fifo_empty), 32'd0);
    chk("rd_reply_msb", 32'(tx_fifo_data), 32'hBE);
    ser_en = 1'b1;
    drain();

    ser_en = 1'b0;
    frame_bad(8'h41);
    chk("bad_err_lat", 32'(frame_err), 32'd1);
    chk("bad_reply_lat", 32'(tx_fifo_empty), 32'd0);
    chk("bad_reply_byte", 32'(tx_fifo_data), 32'h3F);
    ser_en = 1'b1;
    drain();
    frame_wr(8'h20, 16'hCAFE);
    drain();

    ser_en = 1'b0;
    frame_wr(8'h0A, 16'h5555);
    n = 0;
    while (tx_fifo_empty && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_reply_ready", 32'(tx_fifo_empty), 32'd0);
    err_pend++;
    rx_fifo_data = 8'h52;
    rx_fifo_wr_en = 1'b1;
    @(negedge clk);
    rx_fifo_wr_en = 1'b0;
    @(negedge clk);
    chk("ovr_err_seen", 32'(err_pend), 32'd0);
    chk("ovr_reply_kept", 32'(tx_fifo_data), 32'h4B);
    ser_en = 1'b1;
    drain();
    frame_rd(8'h0A);
    drain();

`ifdef PULSE_CMD_TIMEOUT_EN
    err_pend++;
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (90) @(negedge clk);
    chk("tmo_not_early", 32'(err_pend), 32'd1);
    repeat (30) @(negedge clk);
    chk("tmo_fired", 32'(err_pend), 32'd0);
    frame_rd(8'h09);
`else
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (150) @(negedge clk);
    chk("no_tmo_open", 32'(rx_fifo_full), 32'd0);
    exp_wr.push_back({8'h01, 16'h0000});
    exp_tx.push_back(8'h4B);
    ref_mem[1] = 16'h0000;
    send_byte(8'h00);
    send_byte(8'h00);
`endif
    drain();

    send_byte(8'h57);
    send_byte(8'h07);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    frame_wr(8'h30, 16'h0F0F);
    drain();

    repeat (40) begin
      n = $urandom_range(0, 9);
      if (n < 5) begin
        frame_wr(8'($urandom_range(0, 15)), 16'($urandom));
      end else if (n < 9) begin
        frame_rd(8'($urandom_range(0, 15)));
      end else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        frame_bad(op);
      end
      drain();
    end

    repeat (5) @(negedge clk);
    chk("left_tx", 32'(exp_tx.size()), 32'd0);
    chk("left_wr", 32'(exp_wr.size()), 32'd0);
    chk("left_rd", 32'(exp_rd.size()), 32'd0);
    chk("left_err", 32'(err_pend), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
